// File: rtl/fwd_pkg.sv
// Shared types and helpers for the forwarding scoreboard.
// Optional statistics counters are enabled with the FWD_SCOREBOARD_STATS_EN macro.
package fwd_pkg;

    // Stored destination indices are zero-extended to this width.
    // Any REG_AW up to this value is supported.
    localparam int RD_MAX_W = 16;

    // Select value meaning "read the register file".
    localparam int FWD_SEL_RF = 0;

    typedef struct packed {
        logic                valid;
        logic                wb;
        logic                load;
        logic [RD_MAX_W-1:0] rd;
    } entry_t;

    // Width of one bypass select field.
    // NSTAGE >= 2 keeps this at least one bit wide.
    function automatic int fwd_selw(input int nstage);
        return $clog2(nstage);
    endfunction

endpackage

// File: rtl/fwd_scoreboard_if.sv
// Issue/forward bus between the ID stage and the forwarding scoreboard.
// Statistics ports (FWD_SCOREBOARD_STATS_EN) live on the scoreboard itself.
interface fwd_scoreboard_if #(
    parameter int NREAD  = 2,
    parameter int NSTAGE = 3,
    parameter int REG_AW = 5
);
    import fwd_pkg::*;

    localparam int SELW = fwd_selw(NSTAGE);

    logic                    hold_i;
    logic                    flush_i;
    logic                    issue_valid_i;
    logic [NREAD*REG_AW-1:0] issue_rs_i;
    logic [REG_AW-1:0]       issue_rd_i;
    logic                    issue_wb_i;
    logic                    issue_load_i;
    logic                    stall_o;
    logic [NREAD*SELW-1:0]   fwd_sel_o;

    modport master (
        output hold_i, flush_i, issue_valid_i, issue_rs_i, issue_rd_i,
               issue_wb_i, issue_load_i,
        input  stall_o, fwd_sel_o
    );

    modport slave (
        input  hold_i, flush_i, issue_valid_i, issue_rs_i, issue_rd_i,
               issue_wb_i, issue_load_i,
        output stall_o, fwd_sel_o
    );

endinterface

// File: rtl/fwd_match.sv
// Combinational youngest-match finder for one source port.
// Only the entries that can still forward are presented (EX .. last-before-WB).
module fwd_match
    import fwd_pkg::*;
#(
    parameter int NSTAGE     = 3,
    parameter int LOAD_STAGE = 2,
    localparam int SELW      = fwd_selw(NSTAGE)
) (
    input  entry_t [NSTAGE-2:0] entries,
    input  logic [RD_MAX_W-1:0] rs,
    output logic                hit,
    output logic                ready,
    output logic [SELW-1:0]     sel
);

    // Walk oldest to youngest so the lowest matching index wins.
    always_comb begin
        hit   = 1'b0;
        ready = 1'b0;
        sel   = SELW'(FWD_SEL_RF);
        for (int j = NSTAGE - 2; j >= 0; j--) begin
            if (entries[j].valid && entries[j].wb &&
                entries[j].rd != '0 && entries[j].rd == rs) begin
                hit   = 1'b1;
                ready = !entries[j].load || ((j + 1) >= LOAD_STAGE);
                sel   = ready ? SELW'(j + 1) : SELW'(FWD_SEL_RF);
            end
        end
    end

endmodule

// File: rtl/fwd_scoreboard.sv
// Forwarding scoreboard: tracks in-flight writers, registers per-port bypass
// selects for the EX cycle and raises a combinational stall on hazards.
// Optional counters stall_cnt_o / fwd_cnt_o exist when FWD_SCOREBOARD_STATS_EN is defined.
module fwd_scoreboard
    import fwd_pkg::*;
#(
    parameter int NREAD      = 2,
    parameter int NSTAGE     = 3,
    parameter int REG_AW     = 5,
    parameter int LOAD_STAGE = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    fwd_scoreboard_if.slave   bus
`ifdef FWD_SCOREBOARD_STATS_EN
    ,
    output logic [31:0]       stall_cnt_o,
    output logic [31:0]       fwd_cnt_o
`endif
);

    localparam int SELW = fwd_selw(NSTAGE);

    // The last tracked stage retires into the write-before-read register file
    // and never forwards, so only entries 0 .. NSTAGE-2 are kept.
    entry_t [NSTAGE-2:0]   entries;
    entry_t                issued;
    logic [NREAD-1:0]      hit;
    logic [NREAD-1:0]      ready;
    logic [NREAD*SELW-1:0] sel_next;
    logic [NREAD*SELW-1:0] sel_q;
    logic                  live;
    logic                  stall;
    logic                  accept;

    for (genvar k = 0; k < NREAD; k++) begin : g_port
        fwd_match #(
            .NSTAGE     (NSTAGE),
            .LOAD_STAGE (LOAD_STAGE)
        ) u_match (
            .entries (entries),
            .rs      (RD_MAX_W'(bus.issue_rs_i[k*REG_AW +: REG_AW])),
            .hit     (hit[k]),
            .ready   (ready[k]),
            .sel     (sel_next[k*SELW +: SELW])
        );
    end

    assign live   = bus.issue_valid_i && !bus.flush_i;
    assign stall  = live && |(hit & ~ready);
    assign accept = live && !stall;

    assign issued.valid = 1'b1;
    assign issued.wb    = bus.issue_wb_i;
    assign issued.load  = bus.issue_load_i;
    assign issued.rd    = RD_MAX_W'(bus.issue_rd_i);

    assign bus.stall_o   = stall;
    assign bus.fwd_sel_o = sel_q;

    // Advance the writer pipeline and capture selects for the next EX cycle.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            entries <= '0;
            sel_q   <= '0;
        end else if (!bus.hold_i) begin
            for (int j = NSTAGE - 2; j >= 1; j--) begin
                entries[j] <= entries[j-1];
            end
            entries[0] <= accept ? issued : '0;
            sel_q      <= accept ? sel_next : '0;
        end
    end

`ifdef FWD_SCOREBOARD_STATS_EN
    // Saturating counts of stall cycles and of accepted forwarding instructions.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stall_cnt_o <= '0;
            fwd_cnt_o   <= '0;
        end else begin
            if (stall && !bus.hold_i && stall_cnt_o != '1) begin
                stall_cnt_o <= stall_cnt_o + 32'd1;
            end
            if (accept && !bus.hold_i && |sel_next && fwd_cnt_o != '1) begin
                fwd_cnt_o <= fwd_cnt_o + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Directed bench for fwd_scoreboard (NREAD=2, NSTAGE=3, LOAD_STAGE=2).
// fwd_sel_o layout: bits [1:0] port 0, bits [3:2] port 1.
module tb_fwd_scoreboard;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    fwd_scoreboard_if #(.NREAD(2), .NSTAGE(3), .REG_AW(5)) bus ();

`ifdef FWD_SCOREBOARD_STATS_EN
    logic [31:0] stall_cnt;
    logic [31:0] fwd_cnt;
`endif

    fwd_scoreboard #(
        .NREAD      (2),
        .NSTAGE     (3),
        .REG_AW     (5),
        .LOAD_STAGE (2)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .bus         (bus.master)
`ifdef FWD_SCOREBOARD_STATS_EN
        ,
        .stall_cnt_o (stall_cnt),
        .fwd_cnt_o   (fwd_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d exp %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input int rs0, input int rs1, input int rd,
                         input logic wb, input logic ld);
        bus.issue_valid_i = v;
        bus.issue_rs_i    = {5'(rs1), 5'(rs0)};
        bus.issue_rd_i    = 5'(rd);
        bus.issue_wb_i    = wb;
        bus.issue_load_i  = ld;
        #1;
    endtask

    task automatic drain();
        drive(1'b0, 0, 0, 0, 1'b0, 1'b0);
        tick();
        tick();
        tick();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus.hold_i  = 1'b0;
        bus.flush_i = 1'b0;
        drive(1'b0, 0, 0, 0, 1'b0, 1'b0);
        tick();
        tick();
        chk("rst_stall", 32'(bus.stall_o), 32'd0);
        chk("rst_sel", 32'(bus.fwd_sel_o), 32'd0);
        rst = 1'b0;
        tick();

        // Back-to-back ALU: add x5; sub x6 = x5 - x5
        drive(1'b1, 1, 2, 5, 1'b1, 1'b0);
        chk("alu_add_stall", 32'(bus.stall_o), 32'd0);
        tick();
        chk("alu_add_sel", 32'(bus.fwd_sel_o), 32'd0);
        drive(1'b1, 5, 5, 6, 1'b1, 1'b0);
        chk("alu_sub_stall", 32'(bus.stall_o), 32'd0);
        tick();
        chk("alu_sub_sel", 32'(bus.fwd_sel_o), 32'h5);
        drain();
        chk("drain_sel", 32'(bus.fwd_sel_o), 32'd0);

        // Load-use: lw x7; add x8 = x7 + x0
        drive(1'b1, 0, 0, 7, 1'b1, 1'b1);
        tick();
        drive(1'b1, 7, 0, 8, 1'b1, 1'b0);
        chk("lu_stall", 32'(bus.stall_o), 32'd1);
        tick();
        chk("lu_bubble_sel", 32'(bus.fwd_sel_o), 32'd0);
        chk("lu_stall_gone", 32'(bus.stall_o), 32'd0);
        tick();
        chk("lu_sel", 32'(bus.fwd_sel_o), 32'h2);
        drain();

        // Distance 2: x3 writer, one unrelated, reader on port 1
        drive(1'b1, 0, 0, 3, 1'b1, 1'b0);
        tick();
        drive(1'b1, 0, 0, 9, 1'b1, 1'b0);
        tick();
        drive(1'b1, 0, 3, 10, 1'b1, 1'b0);
        tick();
        chk("dist2_sel", 32'(bus.fwd_sel_o), 32'h8);
        drain();

        // Distance 3: writer has retired into the register file
        drive(1'b1, 0, 0, 3, 1'b1, 1'b0);
        tick();
        drive(1'b1, 0, 0, 9, 1'b1, 1'b0);
        tick();
        drive(1'b1, 0, 0, 11, 1'b1, 1'b0);
        tick();
        drive(1'b1, 3, 3, 10, 1'b1, 1'b0);
        tick();
        chk("dist3_sel", 32'(bus.fwd_sel_o), 32'd0);
        drain();

        // Youngest wins: two writers of x4, then reader
        drive(1'b1, 0, 0, 4, 1'b1, 1'b0);
        tick();
        drive(1'b1, 0, 0, 4, 1'b1, 1'b0);
        tick();
        drive(1'b1, 4, 0, 15, 1'b1, 1'b0);
        tick();
        chk("young_sel", 32'(bus.fwd_sel_o), 32'h1);
        drain();

        // x0: a load targeting x0 never matches
        drive(1'b1, 0, 0, 0, 1'b1, 1'b1);
        tick();
        drive(1'b1, 0, 0, 16, 1'b1, 1'b0);
        chk("x0_stall", 32'(bus.stall_o), 32'd0);
        tick();
        chk("x0_sel", 32'(bus.fwd_sel_o), 32'd0);
        drain();

        // Hold for 3 cycles: state and selects frozen
        drive(1'b1, 0, 0, 12, 1'b1, 1'b0);
        tick();
        drive(1'b1, 12, 0, 13, 1'b1, 1'b0);
        tick();
        chk("hold_pre_sel", 32'(bus.fwd_sel_o), 32'h1);
        bus.hold_i = 1'b1;
        drive(1'b1, 0, 12, 14, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("hold_sel", 32'(bus.fwd_sel_o), 32'h1);
        end
        bus.hold_i = 1'b0;
        tick();
        chk("hold_post_sel", 32'(bus.fwd_sel_o), 32'h8);
        drain();

        // Flush during load-use
        drive(1'b1, 0, 0, 7, 1'b1, 1'b1);
        tick();
        bus.flush_i = 1'b1;
        drive(1'b1, 7, 0, 8, 1'b1, 1'b0);
        chk("flush_stall", 32'(bus.stall_o), 32'd0);
        tick();
        chk("flush_sel", 32'(bus.fwd_sel_o), 32'd0);
        bus.flush_i = 1'b0;
        drive(1'b1, 7, 7, 8, 1'b1, 1'b0);
        chk("flush_next_stall", 32'(bus.stall_o), 32'd0);
        tick();
        chk("flush_next_sel", 32'(bus.fwd_sel_o), 32'hA);
        drain();

        // Async reset while a load sits in EX and the reader is stalled
        drive(1'b1, 0, 0, 20, 1'b1, 1'b0);
        tick();
        drive(1'b1, 20, 0, 7, 1'b1, 1'b1);
        tick();
        chk("ar_pre_sel", 32'(bus.fwd_sel_o), 32'h1);
        drive(1'b1, 7, 0, 8, 1'b1, 1'b0);
        chk("ar_pre_stall", 32'(bus.stall_o), 32'd1);
        #1;
        rst = 1'b1;
        #1;
        chk("ar_stall", 32'(bus.stall_o), 32'd0);
        chk("ar_sel", 32'(bus.fwd_sel_o), 32'd0);
        tick();
        rst = 1'b0;
        tick();
        chk("ar_after_sel", 32'(bus.fwd_sel_o), 32'd0);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fwd_scoreboard.md
Name: fwd_scoreboard

Overview:
- Parametrised successor to the pipeline's combinational forwarding unit.
- Keeps its own shift register of in-flight writers: one entry per tracked stage, from EX to last-before-retire.
- When an instruction issues from ID, computes its per-source bypass selects and registers them for its EX cycle.
- Raises a combinational stall on load-use or other not-yet-ready hazards. Supports N read ports and configurable load latency.

Parameters:
- NREAD, 2, number of source operands per instruction.
- NSTAGE, 3, tracked stages after ID (entry 0 = EX, 1 = MEM, 2 = WB); must be ≥2.
- REG_AW, 5, register index width.
- LOAD_STAGE, 2, first stage index at which load data can be forwarded; range 1..NSTAGE-1.
- SELW, $clog2(NSTAGE), width of one select field (derived, not overridable).

Ports:
- clk_i, input, 1, clock.
- rst_i, input, 1, reset, asynchronous, active-high.
- hold_i, input, 1, global pipeline freeze (e.g. memory wait).
- flush_i, input, 1, discard the instruction currently in ID.
- issue_valid_i, input, 1, ID holds a real instruction.
- issue_rs_i, input, NREAD*REG_AW, source indices; port k = bits [k*REG_AW +: REG_AW].
- issue_rd_i, input, REG_AW, destination index.
- issue_wb_i, input, 1, instruction writes rd.
- issue_load_i, input, 1, instruction is a load.
- stall_o, output, 1, combinational; ID must hold and a bubble enters EX.
- fwd_sel_o, output, NREAD*SELW, registered per-port select for the instruction in EX: 0 = register file, s = pipeline register after stage s-1 (1 = EX/MEM, 2 = MEM/WB, ...).

Behaviour:
- Clock and reset:
  - One clock: clk_i.
  - Reset is asynchronous and active-high on rst_i.
- State: entry[0..NSTAGE-1], each {valid, wb, load, rd}.
- Reset values: all entries invalid; fwd_sel_o = 0; stall_o follows inputs (0 when issue_valid_i = 0).
- Match for port k against entry j: valid && wb && rd != 0 && rd == rs_k. The youngest match (lowest j) wins.
- Readiness: a matching entry j is ready next cycle if (j+1) ≥ LOAD_STAGE for a load, or (j+1) ≥ 1 for a non-load (always ready). j = NSTAGE-1 shifts out and reads the register file (write-before-read regfile), so it is not a match.
- Hazard condition:
  - stall_o = issue_valid_i && !flush_i && any port's youngest match is not ready.
  - A non-ready youngest match stalls even if an older ready entry matches.
- Per clock edge, priority order:
  1. hold_i = 1: no state change; fwd_sel_o holds.
  2. Otherwise the shift: entry[j+1] <= entry[j] for all j; entry[NSTAGE-1] retires.
     - entry[0] <= issued instruction if issue_valid_i && !flush_i && !stall_o; otherwise a bubble (valid = 0).
     - fwd_sel_o <= per port (youngest ready match j) ? j+1 : 0 when the instruction is accepted; all-zero otherwise (bubble).
- Latency: selects appear exactly 1 cycle after the accept edge, aligned to the EX cycle.
- Stall repetition: a stalled instruction re-evaluates every cycle, since stall_o is not latched. Load-use with LOAD_STAGE = 2 costs exactly 1 bubble.
- Flush vs stall: flush_i with a concurrent hazard → stall_o = 0, a bubble is inserted, and no stall is raised.
- Duplicate sources: the same register on several ports yields identical selects.
- rd = 0 never matches, including for loads.
- Reset mid-stall: state clears immediately; stall_o drops once the blocking entry is gone.

Optional Feature:
- Macro: FWD_SCOREBOARD_STATS_EN.
- When defined, adds:
  - output stall_cnt_o[31:0]: +1 per cycle with stall_o && !hold_i.
  - output fwd_cnt_o[31:0]: +1 per accepted instruction with any nonzero select.
  - Both saturate at all-ones and reset to 0.
- When undefined, these ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Shared package fwd_pkg holds:
  - the entry struct typedef {valid, wb, load, rd};
  - the FWD_SEL_RF = 0 constant;
  - a function computing SELW from NSTAGE.
- One natural sub-module: fwd_match, the combinational per-port youngest-match finder. It returns {hit, ready, sel} and is instantiated NREAD times.

Test Plan:
- Back-to-back ALU: issue add x5 then sub rs1 = x5, rs2 = x5 → no stall; fwd_sel_o = {1,1} in the sub's EX cycle.
- Load-use: lw x7 then add rs1 = x7 → stall_o = 1 for exactly 1 cycle, bubble inserted; next accept gives sel port0 = 2.
- Distance 2 and retire: writer x3, one unrelated instruction, then reader x3 → sel = 2. With two unrelated instructions in between → sel = 0.
- Youngest wins and x0: two consecutive writers of x4, then reader x4 → sel = 1, not 2. A writer of x0 followed by a reader of x0 → sel = 0, no stall.
- Hold and flush:
  - hold_i asserted 3 cycles mid-stream → entries and fwd_sel_o unchanged.
  - flush_i during a load-use hazard → stall_o = 0, bubble inserted, next fwd_sel_o = 0.
- Async reset while the load entry sits in entry 0 and stall_o = 1 → stall_o falls without a clock edge; fwd_sel_o = 0.
